reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- 4-entry reservation station that sits directly upstream of the age-based issue selector.
- Accepts dispatched micro-ops and holds their source operands.
- Wakes operands by snooping the common data bus (CDB).
- Drives the selector with per-entry free and ready vectors, consumes its one-hot selection, and launches the selected op to the functional unit with registered outputs.

Parameters:
- NUM_ENTRIES, 4, number of RS slots; must match the issue selector width.
- TAG_W, 4, physical/ROB tag width.
- DATA_W, 32, operand data width.
- OP_W, 4, opcode width.

Ports:
- clk_i  in  1  clock, rising edge
- reset_i  in  1  synchronous, active-high reset
- flush_i  in  1  synchronous clear of all entries (mispredict)
- alloc_valid_i  in  1  dispatch presents an op
- alloc_ready_o  out  1  at least one entry free
- alloc_op_i  in  OP_W  opcode
- alloc_dst_tag_i  in  TAG_W  destination tag
- alloc_src1_tag_i / alloc_src2_tag_i  in  TAG_W  source tags
- alloc_src1_rdy_i / alloc_src2_rdy_i  in  1  source value already available
- alloc_src1_val_i / alloc_src2_val_i  in  DATA_W  source values, used when rdy=1
- cdb_valid_i  in  1  CDB broadcast valid
- cdb_tag_i  in  TAG_W  broadcast tag
- cdb_data_i  in  DATA_W  broadcast value
- alloc_fire_o  out  1  alloc handshake, = alloc_valid_i & alloc_ready_o; drives selector allocate_i
- entry_free_o  out  NUM_ENTRIES  1 = slot free; drives selector resource_valid_i
- entry_ready_o  out  NUM_ENTRIES  1 = valid and both operands ready; drives selector entry_ready_i
- entry_sel_i  in  NUM_ENTRIES  one-hot issue grant from the selector
- issue_valid_o  out  1  issued op valid
- issue_op_o  out  OP_W  issued opcode
- issue_dst_tag_o  out  TAG_W  issued destination tag
- issue_src1_val_o / issue_src2_val_o  out  DATA_W  issued operand values

Behaviour:
- Reset / flush:
  - All entries go invalid.
  - entry_free_o = all ones; entry_ready_o = 0.
  - issue_valid_o = 0; all issue payload outputs = 0.
  - flush_i has priority over allocation, wakeup and issue in the same cycle.
- State per entry: valid, op, dst_tag, and for each source {tag, rdy, val}. All of it is registered.
- entry_free_o = ~valid and entry_ready_o = valid & src1.rdy & src2.rdy. Both are pure functions of registered state, so there is no combinational path from alloc_*, cdb_* or entry_sel_i.
- Allocation:
  - On alloc_fire_o the op is written into the lowest-index free entry at the clock edge.
  - alloc_ready_o = |entry_free_o.
  - When full, alloc_ready_o = 0 and the op is not written; dispatch must hold it.
- Allocation/CDB bypass: if cdb_valid_i is high in the allocation cycle and cdb_tag_i equals an incoming source tag with rdy=0, that source is captured as ready with cdb_data_i.
- Wakeup:
  - Each cycle with cdb_valid_i high, every valid entry with a non-ready source whose tag matches sets rdy=1 and val=cdb_data_i.
  - Both sources of one entry may wake in the same cycle.
  - An already-ready source is never overwritten.
- Issue:
  - entry_sel_i is sampled at the edge. If the selected entry is ready, then next cycle issue_valid_o = 1 with that entry's payload, and the entry is invalid (free) from that same cycle.
  - Latency: select at edge N, issue_valid_o visible after edge N, slot reusable by an allocation firing in the cycle after edge N.
  - entry_sel_i = 0, or a selected entry that is not ready: issue_valid_o = 0 next cycle and no state change.
  - Multi-hot entry_sel_i is illegal (assertion); the RTL uses the lowest set bit.
- Simultaneous events:
  - Allocation and issue in the same cycle are independent. Allocation targets a slot that is free in current state, so it never collides with the issuing slot.
  - A CDB wakeup aimed at the issuing entry is harmless.
- issue_valid_o is a single-cycle pulse per issue. The functional unit cannot stall.

Decomposition:
- Shared package ooo_pkg holds:
  - NUM_RS_ENTRIES, TAG_W, DATA_W, OP_W
  - tag_t
  - rs_operand_t {tag, rdy, val}
  - rs_entry_t {valid, op, dst_tag, src1, src2}
- One sub-module, rs_operand: a single source slot handling load-on-alloc, the CDB bypass compare, and wakeup capture. It is instantiated 2*NUM_ENTRIES times.
- The lowest-free-slot finder stays inline.

Test Plan:
- Reset: reset_i=1 for one edge -> entry_free_o=4'b1111, entry_ready_o=4'b0000, issue_valid_o=0, alloc_ready_o=1.
- Allocate op with src1_rdy=src2_rdy=0 (tags 3, 5), then op with both rdy=1 -> entry_free_o=4'b1100; entry_ready_o=4'b0010; alloc_fire_o pulses in both cycles.
- CDB tag 3 data 0xAAAA, then tag 5 data 0xBBBB -> entry 0 becomes ready after the second edge; entry_ready_o=4'b0011.
- entry_sel_i=4'b0001 -> next cycle issue_valid_o=1, src1/src2=0xAAAA/0xBBBB, entry_free_o=4'b1101.
- Fill all 4 entries -> alloc_ready_o=0 and a fifth alloc_valid_i is not written. Then issue entry 2 and allocate in the next cycle -> the new op lands in entry 2.
- Alloc with src1 tag 7 rdy=0 while CDB broadcasts tag 7 in the same cycle -> entry is ready immediately after the edge. Then assert flush_i together with alloc_valid_i -> all entries free and nothing written.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: reservation-station sizing and entry layout.
package ooo_pkg;

  localparam int unsigned NUM_RS_ENTRIES = 4;
  localparam int unsigned TAG_W          = 4;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned OP_W           = 4;

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    tag_t              tag;
    logic              rdy;
    logic [DATA_W-1:0] val;
  } rs_operand_t;

  typedef struct packed {
    logic            valid;
    logic [OP_W-1:0] op;
    tag_t            dst_tag;
    rs_operand_t     src1;
    rs_operand_t     src2;
  } rs_entry_t;

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch, CDB, selector and issue signals of the reservation station.
interface reservation_station_if;
  import ooo_pkg::*;

  logic                      alloc_valid_i;
  logic                      alloc_ready_o;
  logic [OP_W-1:0]           alloc_op_i;
  tag_t                      alloc_dst_tag_i;
  tag_t                      alloc_src1_tag_i;
  tag_t                      alloc_src2_tag_i;
  logic                      alloc_src1_rdy_i;
  logic                      alloc_src2_rdy_i;
  logic [DATA_W-1:0]         alloc_src1_val_i;
  logic [DATA_W-1:0]         alloc_src2_val_i;
  logic                      cdb_valid_i;
  tag_t                      cdb_tag_i;
  logic [DATA_W-1:0]         cdb_data_i;
  logic                      alloc_fire_o;
  logic [NUM_RS_ENTRIES-1:0] entry_free_o;
  logic [NUM_RS_ENTRIES-1:0] entry_ready_o;
  logic [NUM_RS_ENTRIES-1:0] entry_sel_i;
  logic                      issue_valid_o;
  logic [OP_W-1:0]           issue_op_o;
  tag_t                      issue_dst_tag_o;
  logic [DATA_W-1:0]         issue_src1_val_o;
  logic [DATA_W-1:0]         issue_src2_val_o;

  // Pipeline side: dispatch, CDB and selector drive the station.
  modport master (
    output alloc_valid_i, alloc_op_i, alloc_dst_tag_i,
           alloc_src1_tag_i, alloc_src2_tag_i, alloc_src1_rdy_i, alloc_src2_rdy_i,
           alloc_src1_val_i, alloc_src2_val_i, cdb_valid_i, cdb_tag_i, cdb_data_i,
           entry_sel_i,
    input  alloc_ready_o, alloc_fire_o, entry_free_o, entry_ready_o,
           issue_valid_o, issue_op_o, issue_dst_tag_o, issue_src1_val_o, issue_src2_val_o
  );

  // Reservation station side.
  modport slave (
    input  alloc_valid_i, alloc_op_i, alloc_dst_tag_i,
           alloc_src1_tag_i, alloc_src2_tag_i, alloc_src1_rdy_i, alloc_src2_rdy_i,
           alloc_src1_val_i, alloc_src2_val_i, cdb_valid_i, cdb_tag_i, cdb_data_i,
           entry_sel_i,
    output alloc_ready_o, alloc_fire_o, entry_free_o, entry_ready_o,
           issue_valid_o, issue_op_o, issue_dst_tag_o, issue_src1_val_o, issue_src2_val_o
  );

endinterface

// File: rtl/rs_operand.sv
// One source-operand slot: load on allocate (with CDB bypass) and CDB wakeup.
module rs_operand
  import ooo_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  tag_t              load_tag_i,
  input  logic              load_rdy_i,
  input  logic [DATA_W-1:0] load_val_i,
  input  logic              watch_i,
  input  logic              cdb_valid_i,
  input  tag_t              cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  output logic              rdy_o,
  output logic [DATA_W-1:0] val_o
);

  rs_operand_t opnd_q;
  logic        load_hit;
  logic        wake_hit;

  // A broadcast in the allocate cycle would otherwise be missed by the new entry.
  assign load_hit = cdb_valid_i && !load_rdy_i && (cdb_tag_i == load_tag_i);
  // Only a live, still-waiting operand captures; ready values are never overwritten.
  assign wake_hit = watch_i && cdb_valid_i && !opnd_q.rdy && (cdb_tag_i == opnd_q.tag);

  // Operand state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      opnd_q <= '0;
    end else if (load_i) begin
      opnd_q.tag <= load_tag_i;
      opnd_q.rdy <= load_rdy_i | load_hit;
      opnd_q.val <= load_rdy_i ? load_val_i : (load_hit ? cdb_data_i : '0);
    end else if (wake_hit) begin
      opnd_q.rdy <= 1'b1;
      opnd_q.val <= cdb_data_i;
    end
  end

  assign rdy_o = opnd_q.rdy;
  assign val_o = opnd_q.val;

endmodule

// File: rtl/reservation_station.sv
// 4-entry reservation station feeding the age-based issue selector.
module reservation_station
  import ooo_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 flush_i,
  reservation_station_if.slave bus
);

  localparam int unsigned NUM_ENTRIES = NUM_RS_ENTRIES;

  logic [NUM_ENTRIES-1:0] valid_q;
  logic [OP_W-1:0]        op_q   [NUM_ENTRIES];
  tag_t                   dst_q  [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] s1_rdy;
  logic [NUM_ENTRIES-1:0] s2_rdy;
  logic [DATA_W-1:0]      s1_val [NUM_ENTRIES];
  logic [DATA_W-1:0]      s2_val [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] free;
  logic [NUM_ENTRIES-1:0] ready;
  logic [NUM_ENTRIES-1:0] alloc_oh;
  logic [NUM_ENTRIES-1:0] sel_oh;
  logic [NUM_ENTRIES-1:0] load;
  logic [NUM_ENTRIES-1:0] issue_clr;
  logic                   alloc_fire;
  logic                   issue_hit;
  logic                   found;

  logic [OP_W-1:0]        mux_op;
  tag_t                   mux_dst;
  logic [DATA_W-1:0]      mux_s1;
  logic [DATA_W-1:0]      mux_s2;

  logic                   issue_valid_q;
  logic [OP_W-1:0]        issue_op_q;
  tag_t                   issue_dst_q;
  logic [DATA_W-1:0]      issue_s1_q;
  logic [DATA_W-1:0]      issue_s2_q;

  assign free       = ~valid_q;
  assign ready      = valid_q & s1_rdy & s2_rdy;
  assign alloc_fire = bus.alloc_valid_i & (|free);
  assign load       = alloc_oh & {NUM_ENTRIES{alloc_fire & ~flush_i}};
  // Lowest set bit of the grant; a legal grant is already one-hot.
  assign sel_oh     = bus.entry_sel_i & (~bus.entry_sel_i + NUM_ENTRIES'(1));
  assign issue_hit  = |(sel_oh & ready);
  assign issue_clr  = sel_oh & {NUM_ENTRIES{issue_hit}};

  // Lowest-index free slot for the incoming op.
  always_comb begin
    alloc_oh = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (free[i] && !found) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Payload of the granted entry.
  always_comb begin
    mux_op  = '0;
    mux_dst = '0;
    mux_s1  = '0;
    mux_s2  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (sel_oh[i]) begin
        mux_op  = op_q[i];
        mux_dst = dst_q[i];
        mux_s1  = s1_val[i];
        mux_s2  = s2_val[i];
      end
    end
  end

  // Entry valid bits: flush wins, issue frees, allocate claims a currently free slot.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= (valid_q & ~issue_clr) | load;
    end
  end

  // Opcode and destination tag capture on allocate.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (reset_i) begin
        op_q[i]  <= '0;
        dst_q[i] <= '0;
      end else if (load[i]) begin
        op_q[i]  <= bus.alloc_op_i;
        dst_q[i] <= bus.alloc_dst_tag_i;
      end
    end
  end

  // Two operand slots per entry.
  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
    rs_operand u_src1 (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .load_i     (load[g]),
      .load_tag_i (bus.alloc_src1_tag_i),
      .load_rdy_i (bus.alloc_src1_rdy_i),
      .load_val_i (bus.alloc_src1_val_i),
      .watch_i    (valid_q[g]),
      .cdb_valid_i(bus.cdb_valid_i),
      .cdb_tag_i  (bus.cdb_tag_i),
      .cdb_data_i (bus.cdb_data_i),
      .rdy_o      (s1_rdy[g]),
      .val_o      (s1_val[g])
    );
    rs_operand u_src2 (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .load_i     (load[g]),
      .load_tag_i (bus.alloc_src2_tag_i),
      .load_rdy_i (bus.alloc_src2_rdy_i),
      .load_val_i (bus.alloc_src2_val_i),
      .watch_i    (valid_q[g]),
      .cdb_valid_i(bus.cdb_valid_i),
      .cdb_tag_i  (bus.cdb_tag_i),
      .cdb_data_i (bus.cdb_data_i),
      .rdy_o      (s2_rdy[g]),
      .val_o      (s2_val[g])
    );
  end

  // Registered issue port; one-cycle pulse per launched op.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      issue_valid_q <= 1'b0;
      issue_op_q    <= '0;
      issue_dst_q   <= '0;
      issue_s1_q    <= '0;
      issue_s2_q    <= '0;
    end else begin
      issue_valid_q <= issue_hit;
      issue_op_q    <= issue_hit ? mux_op  : '0;
      issue_dst_q   <= issue_hit ? mux_dst : '0;
      issue_s1_q    <= issue_hit ? mux_s1  : '0;
      issue_s2_q    <= issue_hit ? mux_s2  : '0;
    end
  end

  assign bus.alloc_ready_o    = |free;
  assign bus.alloc_fire_o     = alloc_fire;
  assign bus.entry_free_o     = free;
  assign bus.entry_ready_o    = ready;
  assign bus.issue_valid_o    = issue_valid_q;
  assign bus.issue_op_o       = issue_op_q;
  assign bus.issue_dst_tag_o  = issue_dst_q;
  assign bus.issue_src1_val_o = issue_s1_q;
  assign bus.issue_src2_val_o = issue_s2_q;

  // The selector must never grant more than one entry.
  a_sel_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
                                 $onehot0(bus.entry_sel_i));

endmodule

// File: tb/tb_reservation_station.sv
// Directed vector table plus randomized run against a behavioural model.
module tb_reservation_station;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  reservation_station_if rs_bus();

  reservation_station dut (
    .clk_i  (clk),
    .reset_i(reset),
    .flush_i(flush),
    .bus    (rs_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Current-cycle stimulus.
  int unsigned s_rst, s_flush, s_av, s_op, s_dst, s_t1, s_r1, s_v1, s_t2, s_r2, s_v2;
  int unsigned s_cv, s_ct, s_cd, s_sel;

  typedef struct {
    int unsigned flush, av, op, dst, t1, r1, v1, t2, r2, v2, cv, ct, cd, sel;
    int unsigned e_ardy, e_fire, e_free, e_ready, e_iv, e_op, e_dst, e_s1, e_s2;
  } vec_t;

  // Reference model: the station as a list of slots.
  bit          m_valid [4];
  int unsigned m_op [4], m_dst [4];
  bit          m_r1 [4], m_r2 [4];
  int unsigned m_t1 [4], m_t2 [4], m_v1 [4], m_v2 [4];
  int unsigned m_iv, m_iop, m_idst, m_is1, m_is2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    reset                   = 1'(s_rst);
    flush                   = 1'(s_flush);
    rs_bus.alloc_valid_i    = 1'(s_av);
    rs_bus.alloc_op_i       = 4'(s_op);
    rs_bus.alloc_dst_tag_i  = 4'(s_dst);
    rs_bus.alloc_src1_tag_i = 4'(s_t1);
    rs_bus.alloc_src1_rdy_i = 1'(s_r1);
    rs_bus.alloc_src1_val_i = 32'(s_v1);
    rs_bus.alloc_src2_tag_i = 4'(s_t2);
    rs_bus.alloc_src2_rdy_i = 1'(s_r2);
    rs_bus.alloc_src2_val_i = 32'(s_v2);
    rs_bus.cdb_valid_i      = 1'(s_cv);
    rs_bus.cdb_tag_i        = 4'(s_ct);
    rs_bus.cdb_data_i       = 32'(s_cd);
    rs_bus.entry_sel_i      = 4'(s_sel);
  endtask

  task automatic clear_stim();
    s_rst = 0; s_flush = 0; s_av = 0; s_op = 0; s_dst = 0; s_t1 = 0; s_r1 = 0; s_v1 = 0;
    s_t2 = 0; s_r2 = 0; s_v2 = 0; s_cv = 0; s_ct = 0; s_cd = 0; s_sel = 0;
  endtask

  function automatic int unsigned m_free_vec();
    int unsigned f = 0;
    for (int k = 0; k < 4; k++) if (!m_valid[k]) f |= (1 << k);
    return f;
  endfunction

  function automatic int unsigned m_ready_vec();
    int unsigned r = 0;
    for (int k = 0; k < 4; k++) if (m_valid[k] && m_r1[k] && m_r2[k]) r |= (1 << k);
    return r;
  endfunction

  // Apply one clock edge of the specification's rules to the model.
  task automatic model_edge();
    bit pv [4];
    int fk;
    for (int k = 0; k < 4; k++) pv[k] = m_valid[k];
    if (s_rst != 0 || s_flush != 0) begin
      for (int k = 0; k < 4; k++) m_valid[k] = 0;
      m_iv = 0; m_iop = 0; m_idst = 0; m_is1 = 0; m_is2 = 0;
    end else begin
      m_iv = 0;
      for (int k = 0; k < 4; k++) begin
        if (s_sel == (1 << k) && pv[k] && m_r1[k] && m_r2[k]) begin
          m_iv = 1; m_iop = m_op[k]; m_idst = m_dst[k]; m_is1 = m_v1[k]; m_is2 = m_v2[k];
          m_valid[k] = 0;
        end
      end
      if (s_cv != 0) begin
        for (int k = 0; k < 4; k++) begin
          if (pv[k] && !m_r1[k] && m_t1[k] == s_ct) begin m_r1[k] = 1; m_v1[k] = s_cd; end
          if (pv[k] && !m_r2[k] && m_t2[k] == s_ct) begin m_r2[k] = 1; m_v2[k] = s_cd; end
        end
      end
      fk = -1;
      for (int k = 3; k >= 0; k--) if (!pv[k]) fk = k;
      if (s_av != 0 && fk >= 0) begin
        m_valid[fk] = 1; m_op[fk] = s_op; m_dst[fk] = s_dst;
        m_t1[fk] = s_t1; m_t2[fk] = s_t2;
        m_r1[fk] = (s_r1 != 0); m_v1[fk] = s_r1 != 0 ? s_v1 : 0;
        m_r2[fk] = (s_r2 != 0); m_v2[fk] = s_r2 != 0 ? s_v2 : 0;
        if (s_r1 == 0 && s_cv != 0 && s_ct == s_t1) begin m_r1[fk] = 1; m_v1[fk] = s_cd; end
        if (s_r2 == 0 && s_cv != 0 && s_ct == s_t2) begin m_r2[fk] = 1; m_v2[fk] = s_cd; end
      end
    end
  endtask

  vec_t vecs [$];

  initial begin
    clear_stim();
    drive();

    // Reset
    s_rst = 1;
    drive();
    @(posedge clk); #1;
    s_rst = 0;
    drive();
    #1;
    chk("reset_free", 32'(rs_bus.entry_free_o), 32'h0000_000f);
    chk("reset_ready", 32'(rs_bus.entry_ready_o), 32'h0);
    chk("reset_issue_valid", 32'(rs_bus.issue_valid_o), 32'h0);
    chk("reset_alloc_ready", 32'(rs_bus.alloc_ready_o), 32'h1);
    chk("reset_issue_op", 32'(rs_bus.issue_op_o), 32'h0);
    chk("reset_issue_src1", rs_bus.issue_src1_val_o, 32'h0);

    //          fl av op dst t1 r1 v1     t2 r2 v2    cv ct cd        sel      ardy fire free     ready    iv op dst s1       s2
    vecs.push_back('{0, 1, 1, 1, 3, 0, 0,     5, 0, 0,    0, 0, 0,        'b0000,  1, 1, 'b1110, 'b0000, 0, 0, 0, 0,       0});
    vecs.push_back('{0, 1, 2, 2, 0, 1, 'h11,  0, 1, 'h22, 0, 0, 0,        'b0000,  1, 1, 'b1100, 'b0010, 0, 0, 0, 0,       0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0,     0, 0, 0,    1, 3, 'hAAAA,   'b0000,  1, 0, 'b1100, 'b0010, 0, 0, 0, 0,       0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0,     0, 0, 0,    1, 5, 'hBBBB,   'b0000,  1, 0, 'b1100, 'b0011, 0, 0, 0, 0,       0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0,     0, 0, 0,    0, 0, 0,        'b0001,  1, 0, 'b1101, 'b0010, 1, 1, 1, 'hAAAA,  'hBBBB});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0,     0, 0, 0,    0, 0, 0,        'b0000,  1, 0, 'b1101, 'b0010, 0, 0, 0, 0,       0});
    vecs.push_back('{0, 1, 3, 3, 8, 0, 0,     9, 0, 0,    0, 0, 0,        'b0000,  1, 1, 'b1100, 'b0010, 0, 0, 0, 0,       0});
    vecs.push_back('{0, 1, 4, 4, 0, 1, 'h33,  0, 1, 'h44, 0, 0, 0,        'b0000,  1, 1, 'b1000, 'b0110, 0, 0, 0, 0,       0});
    vecs.push_back('{0, 1, 5, 5, 0, 1, 'h55,  0, 1, 'h66, 0, 0, 0,        'b0000,  1, 1, 'b0000, 'b1110, 0, 0, 0, 0,       0});
    vecs.push_back('{0, 1, 6, 6, 0, 1, 'h77,  0, 1, 'h88, 0, 0, 0,        'b0000,  0, 0, 'b0000, 'b1110, 0, 0, 0, 0,       0});
    vecs.push_back('{0, 1, 6, 6, 0, 1, 'h77,  0, 1, 'h88, 0, 0, 0,        'b0100,  0, 0, 'b0100, 'b1010, 1, 4, 4, 'h33,    'h44});
    vecs.push_back('{0, 1, 6, 6, 0, 1, 'h77,  0, 1, 'h88, 0, 0, 0,        'b0000,  1, 1, 'b0000, 'b1110, 0, 0, 0, 0,       0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0,     0, 0, 0,    0, 0, 0,        'b0100,  0, 0, 'b0100, 'b1010, 1, 6, 6, 'h77,    'h88});
    vecs.push_back('{0, 1, 7, 7, 7, 0, 0,     0, 1, 'h99, 1, 7, 'h1234,   'b0000,  1, 1, 'b0000, 'b1110, 0, 0, 0, 0,       0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0,     0, 0, 0,    0, 0, 0,        'b0100,  0, 0, 'b0100, 'b1010, 1, 7, 7, 'h1234,  'h99});
    vecs.push_back('{1, 1, 8, 8, 0, 1, 'h5,   0, 1, 'h6,  1, 8, 'hDEAD,   'b0010,  1, 1, 'b1111, 'b0000, 0, 0, 0, 0,       0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0,     0, 0, 0,    0, 0, 0,        'b0000,  1, 0, 'b1111, 'b0000, 0, 0, 0, 0,       0});

    // Directed table
    foreach (vecs[n]) begin
      s_flush = vecs[n].flush; s_av = vecs[n].av; s_op = vecs[n].op; s_dst = vecs[n].dst;
      s_t1 = vecs[n].t1; s_r1 = vecs[n].r1; s_v1 = vecs[n].v1;
      s_t2 = vecs[n].t2; s_r2 = vecs[n].r2; s_v2 = vecs[n].v2;
      s_cv = vecs[n].cv; s_ct = vecs[n].ct; s_cd = vecs[n].cd; s_sel = vecs[n].sel;
      drive();
      #1;
      chk($sformatf("v%0d_alloc_ready", n), 32'(rs_bus.alloc_ready_o), vecs[n].e_ardy);
      chk($sformatf("v%0d_alloc_fire", n), 32'(rs_bus.alloc_fire_o), vecs[n].e_fire);
      @(posedge clk); #1;
      clear_stim();
      drive();
      chk($sformatf("v%0d_free", n), 32'(rs_bus.entry_free_o), vecs[n].e_free);
      chk($sformatf("v%0d_ready", n), 32'(rs_bus.entry_ready_o), vecs[n].e_ready);
      chk($sformatf("v%0d_issue_valid", n), 32'(rs_bus.issue_valid_o), vecs[n].e_iv);
      if (vecs[n].e_iv != 0) begin
        chk($sformatf("v%0d_issue_op", n), 32'(rs_bus.issue_op_o), vecs[n].e_op);
        chk($sformatf("v%0d_issue_dst", n), 32'(rs_bus.issue_dst_tag_o), vecs[n].e_dst);
        chk($sformatf("v%0d_issue_src1", n), rs_bus.issue_src1_val_o, vecs[n].e_s1);
        chk($sformatf("v%0d_issue_src2", n), rs_bus.issue_src2_val_o, vecs[n].e_s2);
      end
    end

    // Randomized run against the model, starting from reset
    clear_stim();
    s_rst = 1;
    drive();
    @(posedge clk); #1;
    model_edge();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      s_rst   = ($urandom_range(0, 199) == 0) ? 1 : 0;
      s_flush = ($urandom_range(0, 49) == 0) ? 1 : 0;
      s_av    = $urandom_range(0, 1);
      s_op    = $urandom_range(0, 15);
      s_dst   = $urandom_range(0, 15);
      s_t1    = $urandom_range(0, 7);
      s_t2    = $urandom_range(0, 7);
      s_r1    = ($urandom_range(0, 3) == 0) ? 1 : 0;
      s_r2    = ($urandom_range(0, 3) == 0) ? 1 : 0;
      s_v1    = $urandom;
      s_v2    = $urandom;
      s_cv    = $urandom_range(0, 1);
      s_ct    = $urandom_range(0, 7);
      s_cd    = $urandom;
      s_sel   = ($urandom_range(0, 1) == 0) ? 0 : (1 << $urandom_range(0, 3));
      drive();
      #1;
      chk("rnd_alloc_ready", 32'(rs_bus.alloc_ready_o), (m_free_vec() != 0) ? 1 : 0);
      chk("rnd_alloc_fire", 32'(rs_bus.alloc_fire_o), (s_av != 0 && m_free_vec() != 0) ? 1 : 0);
      @(posedge clk); #1;
      model_edge();
      chk("rnd_free", 32'(rs_bus.entry_free_o), m_free_vec());
      chk("rnd_ready", 32'(rs_bus.entry_ready_o), m_ready_vec());
      chk("rnd_issue_valid", 32'(rs_bus.issue_valid_o), m_iv);
      if (m_iv != 0) begin
        chk("rnd_issue_op", 32'(rs_bus.issue_op_o), m_iop);
        chk("rnd_issue_dst", 32'(rs_bus.issue_dst_tag_o), m_idst);
        chk("rnd_issue_src1", rs_bus.issue_src1_val_o, m_is1);
        chk("rnd_issue_src2", rs_bus.issue_src2_val_o, m_is2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
